lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store stage directly downstream of the ALU in the single-cycle RISC-V core.
//  Takes the ALU result as the effective address and rs2 data as store data.
//  Runs a req/gnt/rvalid transaction to data memory.
//  Returns aligned, sign/zero-extended load data plus rd to the register-file write port.
//  Stalls the core (holds PC and regfile write) while a transaction is outstanding.
// PARAMETERS
//  DATA_WIDTH     32   datapath / memory word width (fixed 32; byte lanes = 4)
//  ADDRESS_WIDTH  5    register index width (rd)
//  TIMEOUT_CYCLES 255  max cycles waiting in REQ or WAIT before abort
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mem_read   in   1   current instruction is a load
//  mem_write  in   1   current instruction is a store
//  funct3     in   3   LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010
//  ALUout     in   32  effective byte address
//  wdata      in   32  store data (rs2)
//  rd         in   5   load destination register
//  stall      out  1   combinational; hold PC/regfile this cycle
//  wb_valid   out  1   1-cycle pulse: rdata/wb_rd valid, write regfile
//  wb_rd      out  5   registered destination
//  rdata      out  32  registered extended load data
//  st_done    out  1   1-cycle pulse: store accepted by memory
//  mem_err    out  1   1-cycle pulse: misaligned, illegal funct3, or timeout
//  mem_req    out  1   request to memory, registered
//  mem_we     out  1   1 = write
//  mem_addr   out  32  word address {ALUout[31:2],2'b00}
//  mem_wdata  out  32  lane-replicated store data
//  mem_be     out  4   byte enables
//  mem_gnt    in   1   memory accepts request this cycle
//  mem_rvalid in   1   read data valid (earliest: cycle after gnt)
//  mem_rdata  in   32  read word
// BEHAVIOUR
//  Reset:
//   - state IDLE.
//   - All outputs 0, including rdata and wb_rd.
//   - Timeout counter 0.
//   - mem_req drops asynchronously.
//  FSM:
//   - IDLE->REQ on a valid op (op = mem_read|mem_write, legal, aligned); address, data, be, rd, kind are captured.
//   - REQ: mem_req=1, outputs held stable until mem_gnt. On gnt: store->RESP, load->WAIT.
//   - WAIT: mem_req=0. On mem_rvalid: extract and extend, load rdata -> RESP.
//   - RESP: wb_valid (load) or st_done (store) = 1 for one cycle -> IDLE.
//  Stall and latency:
//   - stall = op & legal & ~(state==RESP).
//   - The core advances in the RESP cycle; the new instruction is sampled in IDLE on the next cycle.
//   - Min latency with gnt on first REQ cycle and rvalid on the next: load = 4 cycles capture->RESP, store = 3 cycles.
//  Alignment:
//   - LH/LHU/SH need ALUout[0]==0; LW/SW need ALUout[1:0]==0.
//   - Funct3 011/110/111, or store funct3 >= 011, is illegal.
//   - Illegal or misaligned op in IDLE: no request, mem_err pulses next cycle, stall=0, rdata unchanged.
//  Simultaneous mem_read and mem_write: load wins, store ignored.
//  Store lanes:
//   - SB: be = 4'b0001<<ALUout[1:0], wdata[7:0] replicated x4.
//   - SH: be = 0011 or 1100, wdata[15:0] x2.
//   - SW: be = 1111.
//  Load extract:
//   - Byte/half selected by captured addr[1:0].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//  Timeout:
//   - Counter clears on entering REQ and on gnt; increments each REQ/WAIT cycle.
//   - At TIMEOUT_CYCLES: abort to IDLE, mem_err pulse, no wb_valid.
//   - The core sees stall=0 in the abort cycle.
//  Stray input: mem_rvalid outside WAIT is ignored, including after reset mid-transaction.
//  Reset mid-operation: transaction dropped, no wb_valid/st_done.
// STRUCTURE
//  cpu_pkg:
//   - lsu_state_t {IDLE,REQ,WAIT,RESP}.
//   - funct3 localparams F3_B/H/W/BU/HU.
//  lsu_align: combinational sub-module for be/wdata lane steering and load extract/extend.
//  Top contains FSM, capture regs, timeout counter.
// TESTING
//  LW 0x100, gnt 1st cycle, rvalid next, rdata 0xDEADBEEF -> wb_valid 4th cycle, rdata 0xDEADBEEF, stall 1,1,1,0.
//  LB 0x103, word 0x80FF_0000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
//  SB 0x101, wdata 0x000000AB -> mem_be 0010, mem_wdata 0xABABABAB, mem_addr 0x100; SH 0x102 -> be 1100.
//  SW 0x102 -> no mem_req, mem_err pulse, stall 0; funct3 011 load -> same.
//  gnt held low 3 cycles -> mem_req/addr stable; no gnt for 255 cycles -> mem_err, back to IDLE.
//  rst asserted while in WAIT -> mem_req 0 immediately; late rvalid -> no wb_valid.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LSU types, funct3 encodings and legality helpers.
// Imported by the LSU interface, aligner and memory stage.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(
        input logic       is_load,
        input logic [2:0] f3
    );
        if (is_load)
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

    // Low two funct3 bits encode access size for loads and stores.
    function automatic logic addr_aligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the LSU and memory.
// master = LSU side (drives request), slave = memory side.
interface lsu_mem_stage_if;
    import cpu_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Ports: funct3/off select size and lane; wdata/rword in; be, wdata_rep, rdata_ext out.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign shifted  = rword >> {off, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        rdata_ext = rword;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'b0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'b0, half_sel};
            default: rdata_ext = rword;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: FSM, capture registers and timeout for the dmem bus.
// Ports: clk/rst, core op inputs, stall/writeback/status outputs, dmem master bus.
module lsu_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    ALUout,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     stall,
    output logic                     wb_valid,
    output logic [ADDRESS_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     st_done,
    output logic                     mem_err,
    lsu_mem_stage_if.master          dmem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t state_q, state_d;

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
    logic [3:0]               be_q, be_d;
    logic                     we_q, we_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic [ADDRESS_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     req_q, req_d;
    logic                     wbv_q, wbv_d;
    logic                     std_q, std_d;
    logic                     err_q, err_d;

    logic                  op;
    logic                  legal;
    logic                  abort;
    logic                  timeout_hit;
    logic [2:0]            al_f3;
    logic [1:0]            al_off;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;

    assign op    = mem_read | mem_write;
    // mem_read wins when both are set, so legality follows the load table.
    assign legal = op
                 & f3_legal(mem_read, funct3)
                 & addr_aligned(funct3, ALUout[1:0]);

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Steer live inputs while capturing, captured fields while loading.
    assign al_f3  = (state_q == IDLE) ? funct3 : f3_q;
    assign al_off = (state_q == IDLE) ? ALUout[1:0] : off_q;

    lsu_align u_align (
        .funct3    (al_f3),
        .off       (al_off),
        .wdata     (wdata),
        .rword     (dmem.mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        wb_rd_d = wb_rd_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        abort   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = {ALUout[DATA_WIDTH-1:2], 2'b00};
                    wdat_d  = al_wdata;
                    be_d    = al_be;
                    we_d    = ~mem_read;
                    f3_d    = funct3;
                    off_d   = ALUout[1:0];
                    rd_d    = rd;
                end else if (op) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                if (dmem.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (dmem.mem_rvalid) begin
                    rdata_d = al_rdata;
                    wb_rd_d = rd_q;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == REQ);
        wbv_d = (state_d == RESP) & ~we_q;
        std_d = (state_d == RESP) & we_q;
        // Release the core in RESP and in the abort cycle.
        stall = legal & (state_q != RESP) & ~abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            wb_rd_q <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            wbv_q   <= 1'b0;
            std_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            wb_rd_q <= wb_rd_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            wbv_q   <= wbv_d;
            std_q   <= std_d;
            err_q   <= err_d;
        end
    end

    assign dmem.mem_req   = req_q;
    assign dmem.mem_we    = we_q;
    assign dmem.mem_addr  = addr_q;
    assign dmem.mem_wdata = wdat_q;
    assign dmem.mem_be    = be_q;

    assign wb_valid = wbv_q;
    assign st_done  = std_q;
    assign mem_err  = err_q;
    assign wb_rd    = wb_rd_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage with a reactive memory model.
// Directed cases first, then randomized load/store traffic.
module tb_lsu_mem_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] ALUout, wdata;
    logic [4:0]  rd;
    logic        stall, wb_valid, st_done, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] rdata;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(
        .DATA_WIDTH     (32),
        .ADDRESS_WIDTH  (5),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .ALUout    (ALUout),
        .wdata     (wdata),
        .rd        (rd),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .rdata     (rdata),
        .st_done   (st_done),
        .mem_err   (mem_err),
        .dmem      (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t       sb_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem[logic [31:0]];

    bit          slave_en  = 1'b1;
    bit          rand_lat  = 1'b0;
    bit          gnt_block = 1'b0;
    int          gnt_cfg   = 0;
    int          rv_cfg    = 0;
    int          gnt_wait  = 0;
    int          rv_wait   = 0;
    bit          rd_pending = 1'b0;
    logic [31:0] pend_word;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Memory slave: grants after gnt_wait cycles, returns data rv_wait later.
    initial begin : slave
        bus_t e;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
                if (rd_pending) begin
                    if (rv_wait == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = pend_word;
                        rd_pending     = 1'b0;
                    end else begin
                        rv_wait--;
                    end
                end else if (bus.mem_req === 1'b1) begin
                    if (bus_q.size() == 0) begin
                        check("req_without_op", {31'b0, bus.mem_req}, 32'd0);
                    end else if (gnt_block || gnt_wait > 0) begin
                        check("req_addr_stable", bus.mem_addr, bus_q[0].addr);
                        if (!gnt_block) gnt_wait--;
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_addr", bus.mem_addr, e.addr);
                        check("bus_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                        if (e.we) begin
                            check("bus_be", {28'b0, bus.mem_be}, {28'b0, e.be});
                            check("bus_wdata", bus.mem_wdata, e.wdata);
                        end else begin
                            rd_pending = 1'b1;
                            pend_word  = mem[e.addr];
                            rv_wait    = rand_lat ? $urandom_range(0, 2) : rv_cfg;
                        end
                        bus.mem_gnt = 1'b1;
                        gnt_wait    = rand_lat ? $urandom_range(0, 3) : gnt_cfg;
                    end
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest expectation.
    initial begin : monitor
        resp_t      e;
        logic [2:0] seen, want;
        forever begin
            @(negedge clk);
            seen = {wb_valid, st_done, mem_err};
            if (!rst && seen != 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", {29'b0, seen}, 32'd0);
                end else begin
                    e    = sb_q.pop_front();
                    want = (e.kind == 0) ? 3'b100 :
                           (e.kind == 1) ? 3'b010 : 3'b001;
                    check("resp_kind", {29'b0, seen}, {29'b0, want});
                    if (e.kind == 0) begin
                        check("wb_rdata", rdata, e.data);
                        check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                    end
                end
            end
        end
    end

    // Reference model + core driver: holds the op while stall is high.
    task automatic issue(input bit r, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] d, input bit expect_to,
                         output int n);
        int          sz, nb, m, sh;
        bit          ok;
        logic [31:0] wa, word, v, wdx;
        logic [3:0]  be;
        sz = int'(f3) % 4;
        ok = r ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
        ok = ok && (r || w) && (int'(a % 4) % (1 << sz) == 0);
        wa = a & ~32'h3;
        sh = int'(a % 4) * 8;
        nb = 1 << sz;
        m  = ((1 << nb) - 1) << (a % 4);
        be = m[3:0];
        wdx = (sz == 0) ? wd[7:0] * 32'h01010101 :
              (sz == 1) ? wd[15:0] * 32'h00010001 : wd;
        if (r || w) begin
            if (!ok) begin
                sb_q.push_back('{2, 32'h0, 5'h0});
            end else if (expect_to) begin
                bus_q.push_back('{wa, !r, be, wdx});
                sb_q.push_back('{2, 32'h0, 5'h0});
            end else if (r) begin
                word = rd_word(wa);
                v    = word >> sh;
                if (sz == 0) begin
                    v = v & 32'hFF;
                    if (f3 < 4 && v >= 128) v = v - 256;
                end else if (sz == 1) begin
                    v = v & 32'hFFFF;
                    if (f3 < 4 && v >= 32768) v = v - 65536;
                end else begin
                    v = word;
                end
                bus_q.push_back('{wa, 1'b0, 4'h0, 32'h0});
                sb_q.push_back('{0, v, d});
            end else begin
                word = rd_word(wa);
                for (int i = 0; i < 4; i++)
                    if (be[i]) word[8*i +: 8] = wdx[8*i +: 8];
                mem[wa] = word;
                bus_q.push_back('{wa, 1'b1, be, wdx});
                sb_q.push_back('{1, 32'h0, 5'h0});
            end
        end
        mem_read  = r;
        mem_write = w;
        funct3    = f3;
        ALUout    = a;
        wdata     = wd;
        rd        = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 600);
        if (stall) check("stall_bound", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        ALUout = '0; wdata = '0; rd = '0;
        repeat (2) @(negedge clk);
        check("rst_status", {28'b0, stall, wb_valid, st_done, mem_err}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_ctl", {26'b0, bus.mem_req, bus.mem_we, bus.mem_be},
              32'd0);
        check("rst_bus_addr", bus.mem_addr, 32'd0);
        check("rst_bus_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        mem[32'h100] = 32'hDEADBEEF;
        issue(1, 0, F3_W, 32'h100, 0, 5'd5, 0, n);
        check("lw_latency", n, 4);

        mem[32'h100] = 32'h80FF0000;
        issue(1, 0, F3_B,  32'h103, 0, 5'd6, 0, n);
        issue(1, 0, F3_BU, 32'h103, 0, 5'd7, 0, n);
        issue(1, 0, F3_H,  32'h102, 0, 5'd8, 0, n);

        issue(0, 1, F3_B, 32'h101, 32'h000000AB, 0, 0, n);
        check("sb_latency", n, 3);
        issue(0, 1, F3_H, 32'h102, 32'h00001234, 0, 0, n);

        issue(0, 1, F3_W, 32'h102, 32'h55, 0, 0, n);
        check("sw_misaligned_stall", n, 1);
        issue(1, 0, 3'b011, 32'h100, 0, 5'd9, 0, n);
        check("illegal_f3_stall", n, 1);
        @(negedge clk);
        check("rdata_kept", rdata, 32'hFFFF80FF);
        @(posedge clk);
        #1;

        issue(1, 1, F3_W, 32'h100, 32'h77, 5'd10, 0, n);
        check("both_is_load", n, 4);

        gnt_cfg = 3; gnt_wait = 3;
        issue(1, 0, F3_W, 32'h104, 0, 5'd11, 0, n);
        check("gnt_late_latency", n, 7);
        gnt_cfg = 0; gnt_wait = 0;

        gnt_block = 1'b1;
        issue(1, 0, F3_W, 32'h108, 0, 5'd12, 1, n);
        check("timeout_stall_cycles", n, 256);
        repeat (2) @(negedge clk);
        gnt_block = 1'b0;
        bus_q.delete();
        @(posedge clk);
        #1;

        slave_en = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        mem_read = 1'b1; funct3 = F3_W; ALUout = 32'h200; rd = 5'd3;
        @(negedge clk);
        @(negedge clk);
        check("req_before_rst", {31'b0, bus.mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1 check("req_async_drop", {31'b0, bus.mem_req}, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("wait_no_req", {31'b0, bus.mem_req}, 32'd0);
        check("wait_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1 mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = (i < 3);
            bus.mem_rdata  = 32'h12345678;
            @(negedge clk);
            check("stray_rvalid_wbv", {31'b0, wb_valid}, 32'd0);
        end
        bus.mem_rvalid = 1'b0;
        check("stray_rvalid_rdata", rdata, 32'd0);
        slave_en = 1'b1;
        @(posedge clk);
        #1;

        rand_lat = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            issue(kind == 1 || kind == 3, kind == 2 || kind == 3,
                  3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 63),
                  $urandom, 5'($urandom), 0, n);
        end

        repeat (6) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("bus_drained", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
